// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_lite_master
// Description : Single-outstanding AXI4-Lite manager. Turns a valid/ready
//               command into one AXI4-Lite write or read. Returns read data,
//               response code and a saturating latency count on a
//               valid/ready response port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_*                : command port (valid/ready, write flag, addr,
//                          wdata, wstrb)
//   rsp_*                : response port (valid/ready, rdata, resp, write
//                          echo, latency cycles)
//   aw*/w*/b*/ar*/r*     : AXI4-Lite manager channels
// ============================================================================
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    // command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_write,
    output logic [LAT_W-1:0]    rsp_cycles,
    // write address channel
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    // write data channel
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // write response channel
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    // read address channel
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    // read data channel
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WADDR_DATA = 3'd1,
        WRESP      = 3'd2,
        RADDR      = 3'd3,
        RDATA      = 3'd4,
        RESP       = 3'd5
    } state_t;

    state_t              state_q,      state_d;
    logic                cmd_ready_q,  cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [DATA_W/8-1:0] wstrb_q,      wstrb_d;
    logic                awvalid_q,    awvalid_d;
    logic                wvalid_q,     wvalid_d;
    logic                arvalid_q,    arvalid_d;
    logic                bready_q,     bready_d;
    logic                rready_q,     rready_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;
    logic [1:0]          rsp_resp_q,   rsp_resp_d;
    logic                rsp_write_q,  rsp_write_d;
    logic [LAT_W-1:0]    rsp_cycles_q, rsp_cycles_d;
    logic [LAT_W-1:0]    lat_q,        lat_d;

    // Latency including the current cycle, clamped at all-ones.
    logic [LAT_W-1:0]    lat_inc;
    // A channel counts as done once its handshake has happened, either in an
    // earlier cycle (valid already dropped) or in this one.
    logic                aw_done;
    logic                w_done;

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        rready_d     = rready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        rsp_write_d  = rsp_write_q;
        rsp_cycles_d = rsp_cycles_q;
        lat_d        = lat_q;

        lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);
        aw_done = !awvalid_q || awready;
        w_done  = !wvalid_q  || wready;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    lat_d       = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end

            WADDR_DATA: begin
                lat_d = lat_inc;
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end

            WRESP: begin
                lat_d = lat_inc;
                if (bvalid && bready_q) begin
                    rsp_resp_d   = bresp;
                    rsp_rdata_d  = '0;
                    rsp_write_d  = 1'b1;
                    rsp_cycles_d = lat_inc;
                    rsp_valid_d  = 1'b1;
                    bready_d     = 1'b0;
                    state_d      = RESP;
                end
            end

            RADDR: begin
                lat_d = lat_inc;
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end

            RDATA: begin
                lat_d = lat_inc;
                if (rvalid && rready_q) begin
                    rsp_rdata_d  = rdata;
                    rsp_resp_d   = rresp;
                    rsp_write_d  = 1'b0;
                    rsp_cycles_d = lat_inc;
                    rsp_valid_d  = 1'b1;
                    rready_d     = 1'b0;
                    state_d      = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                // Unreachable encodings recover to an idle, quiet interface.
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
            rsp_write_q  <= 1'b0;
            rsp_cycles_q <= '0;
            lat_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_write_q  <= rsp_write_d;
            rsp_cycles_q <= rsp_cycles_d;
            lat_q        <= lat_d;
        end
    end

    // Only one transaction is ever in flight, so one address register serves
    // both the write and read address channels.
    assign cmd_ready  = cmd_ready_q;
    assign awaddr     = addr_q;
    assign araddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign awvalid    = awvalid_q;
    assign wvalid     = wvalid_q;
    assign arvalid    = arvalid_q;
    assign bready     = bready_q;
    assign rready     = rready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_cycles = rsp_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master
// Description : Self-checking bench for axi_lite_master. A second instance
//               with a 4-bit latency counter runs in lockstep on the same
//               inputs to exercise saturation. A behavioural subordinate with
//               per-channel wait states answers both instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LAT_W     = 16;
    localparam int SAT_LAT_W = 4;
    localparam int SAT_MAX   = 15;
    localparam int K_MAX     = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [LAT_W-1:0]  rsp_cycles;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    // outputs of the saturating-counter instance
    logic                 s_cmd_ready, s_rsp_valid, s_rsp_write;
    logic [DATA_W-1:0]    s_rsp_rdata;
    logic [1:0]           s_rsp_resp;
    logic [SAT_LAT_W-1:0] s_rsp_cycles;
    logic [ADDR_W-1:0]    s_awaddr, s_araddr;
    logic                 s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [DATA_W-1:0]    s_wdata;
    logic [3:0]           s_wstrb;

    axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_cycles(rsp_cycles),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_W(SAT_LAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata),
        .rsp_resp(s_rsp_resp), .rsp_write(s_rsp_write), .rsp_cycles(s_rsp_cycles),
        .awaddr(s_awaddr), .awvalid(s_awvalid), .awready(awready),
        .wdata(s_wdata), .wstrb(s_wstrb), .wvalid(s_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(s_bready),
        .araddr(s_araddr), .arvalid(s_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(s_rready)
    );

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cur_vec = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h required 0x%0h", cur_vec, name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    // ------------------------------------------------------------------
    // Behavioural subordinate, acting on the falling edge
    // ------------------------------------------------------------------
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  sub_resp = 2'b00;
    logic [31:0] mem [0:63];

    initial begin
        logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, ar_got;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [31:0] aw_lat, w_lat, ar_lat, word;
        logic [3:0]  ws_lat;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0;  rdata = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_lat = 0; w_lat = 0; ar_lat = 0; ws_lat = 0; word = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                // retire handshakes that completed on the last rising edge
                if (aw_hs) begin awready = 0; aw_hs = 0; end
                if (w_hs)  begin wready  = 0; w_hs  = 0; end
                if (ar_hs) begin arready = 0; ar_hs = 0; end
                if (b_hs)  begin bvalid  = 0; b_hs  = 0; end
                if (r_hs)  begin rvalid  = 0; r_hs  = 0; end
                // responses
                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_delay) begin
                        word = mem[aw_lat[7:2]];
                        for (int b = 0; b < 4; b++)
                            if (ws_lat[b]) word[b*8 +: 8] = w_lat[b*8 +: 8];
                        mem[aw_lat[7:2]] = word;
                        bvalid = 1; bresp = sub_resp;
                        aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (ar_got && !rvalid) begin
                    if (r_cnt >= r_delay) begin
                        rdata = mem[ar_lat[7:2]]; rresp = sub_resp; rvalid = 1;
                        ar_got = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                if (bvalid && bready) b_hs = 1;
                if (rvalid && rready) r_hs = 1;
                // address / data acceptance after the configured wait
                if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin
                        awready = 1; aw_hs = 1; aw_got = 1; aw_lat = awaddr; aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (wvalid && !w_got) begin
                    if (w_cnt >= w_delay) begin
                        wready = 1; w_hs = 1; w_got = 1; w_lat = wdata; ws_lat = wstrb; w_cnt = 0;
                    end else w_cnt++;
                end
                if (arvalid && !ar_got) begin
                    if (ar_cnt >= ar_delay) begin
                        arready = 1; ar_hs = 1; ar_got = 1; ar_lat = araddr; ar_cnt = 0;
                    end else ar_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One command through both instances; called on a falling edge
    // ------------------------------------------------------------------
    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          k, aw_off, w_off, bcnt, rcnt, acnt, sat_exp;
        logic        bad_ready, bad_pay, bad_hold;
        logic [70:0] snap;
        aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
        ar_delay = v.ar_d; r_delay = v.r_d; sub_resp = v.resp;
        e.write = v.write; e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.cycles = v.exp_cycles;
        sb.push_back(e);

        check("cmd_ready idle", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        @(negedge clk);
        cmd_valid = 0;
        if (v.write) check("aw+w valid together", {awvalid, wvalid, arvalid}, 3'b110);
        else         check("arvalid only", {awvalid, wvalid, arvalid}, 3'b001);

        k = 1; aw_off = 0; w_off = 0; bcnt = 0; rcnt = 0; acnt = 0;
        bad_ready = 0; bad_pay = 0;
        while (!rsp_valid && k < K_MAX) begin
            if (cmd_ready) bad_ready = 1;
            if (!awvalid && aw_off == 0) aw_off = k;
            if (!wvalid && w_off == 0)   w_off = k;
            if (bready)  bcnt++;
            if (rready)  rcnt++;
            if (arvalid) acnt++;
            if (v.write && (awaddr !== v.addr || wdata !== v.wdata || wstrb !== v.wstrb)) bad_pay = 1;
            if (!v.write && araddr !== v.addr) bad_pay = 1;
            @(negedge clk);
            k++;
        end
        check("rsp within budget", (k < K_MAX), 1'b1);
        check("cmd_ready low in flight", bad_ready, 1'b0);
        check("payload stable", bad_pay, 1'b0);
        if (v.write) begin
            check("awvalid drop cycle", aw_off, v.aw_d + 2);
            check("wvalid drop cycle", w_off, v.w_d + 2);
            check("bready cycles", bcnt, v.b_d + 1);
            check("no read channel", acnt + rcnt, 0);
        end else begin
            check("arvalid cycles", acnt, v.ar_d + 1);
            check("rready cycles", rcnt, v.r_d + 1);
            check("no bready", bcnt, 0);
        end

        // backpressure: response must hold still while rsp_ready is low
        snap = {rsp_rdata, rsp_resp, rsp_write, rsp_cycles, s_rsp_cycles};
        bad_hold = 0;
        repeat (v.hold) begin
            @(negedge clk);
            if ({rsp_rdata, rsp_resp, rsp_write, rsp_cycles, s_rsp_cycles} !== snap ||
                !rsp_valid || cmd_ready) bad_hold = 1;
        end
        check("rsp stable under backpressure", bad_hold, 1'b0);

        rsp_ready = 1;
        check("scoreboard depth", sb.size(), 1);
        e = sb.pop_front();
        sat_exp = (e.cycles > SAT_MAX) ? SAT_MAX : e.cycles;
        check("rsp_write", rsp_write, e.write);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_resp", rsp_resp, e.resp);
        check("rsp_cycles", rsp_cycles, e.cycles);
        check("sat rsp_cycles", s_rsp_cycles, sat_exp);
        check("sat rsp_rdata", s_rsp_rdata, e.rdata);
        check("sat rsp_valid+resp+write", {s_rsp_valid, s_rsp_resp, s_rsp_write}, {1'b1, e.resp, e.write});
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_valid drops, cmd_ready back", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    vec_t vecs [10];
    vec_t post_rst;

    initial begin
        int k;
        //                write  addr   wdata          strb aw w  b  ar  r  resp  hold exp_rdata      exp_resp cyc
        vecs[0] = '{1'b1, 32'h00, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0,  0, 2'b00, 0, 32'h0,         2'b00, 2};
        vecs[1] = '{1'b0, 32'h00, 32'h0,         4'h0, 0, 0, 0, 0,  0, 2'b00, 1, 32'hA5A5_0F0F, 2'b00, 2};
        vecs[2] = '{1'b1, 32'h04, 32'h1122_3344, 4'hF, 3, 0, 0, 0,  0, 2'b00, 0, 32'h0,         2'b00, 5};
        vecs[3] = '{1'b1, 32'h08, 32'h5566_7788, 4'hF, 0, 3, 0, 0,  0, 2'b00, 0, 32'h0,         2'b00, 5};
        vecs[4] = '{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h1122_3344, 2'b00, 2};
        vecs[5] = '{1'b1, 32'h04, 32'hAABB_CCDD, 4'h5, 0, 0, 0, 0,  0, 2'b00, 0, 32'h0,         2'b00, 2};
        vecs[6] = '{1'b0, 32'h04, 32'h0,         4'h0, 0, 0, 0, 0,  2, 2'b00, 0, 32'h11BB_33DD, 2'b00, 4};
        vecs[7] = '{1'b0, 32'h40, 32'h0,         4'h0, 0, 0, 0, 0,  0, 2'b10, 4, 32'h0,         2'b10, 2};
        vecs[8] = '{1'b1, 32'h0C, 32'h1234_5678, 4'hF, 0, 0, 1, 0,  0, 2'b11, 2, 32'h0,         2'b11, 3};
        vecs[9] = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 20, 0, 2'b00, 0, 32'h0,         2'b00, 22};
        post_rst = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h5566_7788, 2'b00, 2};

        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset cmd_ready", {cmd_ready, s_cmd_ready}, 2'b11);
        check("reset valids/readies", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        check("reset payload zero",
              |{awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write, rsp_cycles}, 1'b0);
        check("sat reset outputs zero",
              |{s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid,
                s_rready, s_rsp_valid, s_rsp_rdata, s_rsp_resp, s_rsp_write, s_rsp_cycles}, 1'b0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // reset while waiting in WRESP for a slow B response
        cur_vec = 100;
        aw_delay = 0; w_delay = 0; b_delay = 50; sub_resp = 2'b00;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        k = 0;
        while (!bready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reached WRESP", bready, 1'b1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async reset quiets bus", {bready, awvalid, wvalid, rsp_valid}, 4'b0);
        check("async reset cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("cmd_ready after release", cmd_ready, 1'b1);
        cur_vec = 101;
        run_vec(post_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
